// File: rtl/sys_arr_param.sv
// Weight-stationary ROWS x COLS systolic MAC array with input skew and output deskew.
// Optional macro SYS_ARR_SAT_EN makes every partial-sum addition saturate instead of wrap.
module sys_arr_param #(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int DW   = 8,
   parameter int AW   = 24
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 w_valid,
   output logic                 w_ready,
   input  logic [COLS*DW-1:0]   w_data,
   input  logic                 a_valid,
   output logic                 a_ready,
   input  logic [ROWS*DW-1:0]   a_data,
   input  logic                 a_last,
   output logic                 y_valid,
   output logic [COLS*AW-1:0]   y_data,
   output logic                 busy
);
   localparam int CW  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int LAT = ROWS + COLS;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   state_t               state_reg, state_next;
   logic [CW-1:0]        wcnt_reg, wcnt_next;
   logic [LAT-1:0]       vld_reg;
   logic                 y_valid_reg;
   logic [COLS*AW-1:0]   y_data_reg;
   logic                 w_acc, a_acc;

   // Array interconnect: activations flow right, partial sums flow down.
   logic signed [DW-1:0] act_h   [ROWS][COLS];
   logic signed [AW-1:0] ps_v    [ROWS][COLS];
   logic signed [AW-1:0] dsk_out [COLS];

   assign w_acc   = w_valid & w_ready;
   assign a_acc   = a_valid & a_ready;
   assign y_valid = y_valid_reg;
   assign y_data  = y_data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         wcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      w_ready    = 1'b0;
      a_ready    = 1'b0;
      busy       = 1'b1;
      case (state_reg)
         IDLE, LOAD: begin
            w_ready = 1'b1;
            busy    = (state_reg != IDLE);
            if (w_valid) begin
               if (wcnt_reg == CW'(ROWS - 1)) begin
                  state_next = RUN;
                  wcnt_next  = '0;
               end else begin
                  state_next = LOAD;
                  wcnt_next  = wcnt_reg + 1'b1;
               end
            end
         end
         RUN: begin
            a_ready = 1'b1;
            if (a_valid && a_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Leave once nothing is left in flight; the final y_valid is then on the output.
            if (vld_reg == '0) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_reg <= '0;
      end else begin
         vld_reg <= {vld_reg[LAT-2:0], a_acc};
      end
   end

   // Row gi sees its activation gi cycles after row 0; bubbles inject zeros.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_skew
      logic signed [DW-1:0] sk_reg [gi+1];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int k = 0; k <= gi; k++) begin
               sk_reg[k] <= '0;
            end
         end else begin
            sk_reg[0] <= a_acc ? a_data[gi*DW +: DW] : '0;
            for (int k = 1; k <= gi; k++) begin
               sk_reg[k] <= sk_reg[k-1];
            end
         end
      end

      assign act_h[gi][0] = sk_reg[gi];
   end

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
         logic signed [DW-1:0]   w_reg;
         logic signed [AW-1:0]   ps_reg;
         logic signed [AW-1:0]   ps_in;
         logic signed [AW-1:0]   ps_next;
         logic signed [2*DW-1:0] prod;
         logic signed [AW-1:0]   prod_x;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               w_reg <= '0;
            end else if (w_acc && (wcnt_reg == CW'(gi))) begin
               w_reg <= w_data[gj*DW +: DW];
            end
         end

         if (gi == 0) begin : g_top
            assign ps_in = '0;
         end else begin : g_mid
            assign ps_in = ps_v[gi-1][gj];
         end

         assign prod   = (2*DW)'(act_h[gi][gj]) * (2*DW)'(w_reg);
         assign prod_x = AW'(prod);

`ifdef SYS_ARR_SAT_EN
         localparam logic signed [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
         localparam logic signed [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};
         logic signed [AW:0] sum_w;

         // One guard bit exposes overflow; clamp toward the sign of the true sum.
         assign sum_w   = {ps_in[AW-1], ps_in} + {prod_x[AW-1], prod_x};
         assign ps_next = (sum_w[AW] != sum_w[AW-1]) ? (sum_w[AW] ? SAT_MIN : SAT_MAX)
                                                     : sum_w[AW-1:0];
`else
         assign ps_next = ps_in + prod_x;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ps_reg <= '0;
            end else begin
               ps_reg <= ps_next;
            end
         end

         assign ps_v[gi][gj] = ps_reg;

         if (gj < COLS - 1) begin : g_fwd
            logic signed [DW-1:0] act_reg;

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  act_reg <= '0;
               end else begin
                  act_reg <= act_h[gi][gj];
               end
            end

            assign act_h[gi][gj+1] = act_reg;
         end
      end
   end

   // Column gj finishes gj cycles after column 0, so it waits COLS-1-gj cycles.
   for (genvar gj = 0; gj < COLS; gj++) begin : g_dsk
      localparam int D = COLS - 1 - gj;

      if (D == 0) begin : g_pass
         assign dsk_out[gj] = ps_v[ROWS-1][gj];
      end else begin : g_dly
         logic signed [AW-1:0] d_reg [D];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < D; k++) begin
                  d_reg[k] <= '0;
               end
            end else begin
               d_reg[0] <= ps_v[ROWS-1][gj];
               for (int k = 1; k < D; k++) begin
                  d_reg[k] <= d_reg[k-1];
               end
            end
         end

         assign dsk_out[gj] = d_reg[D-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_valid_reg <= 1'b0;
         y_data_reg  <= '0;
      end else begin
         y_valid_reg <= vld_reg[LAT-1];
         if (vld_reg[LAT-1]) begin
            for (int c = 0; c < COLS; c++) begin
               y_data_reg[c*AW +: AW] <= dsk_out[c];
            end
         end
      end
   end

endmodule

// File: tb/tb_sys_arr_param.sv
// Self-checking bench for sys_arr_param: random vectors against a dot-product model,
// with directed identity, overflow, bubble, drain and mid-run reset steps.
module tb_sys_arr_param;
   localparam int ROWS = 4;
   localparam int COLS = 3;
   localparam int DW   = 8;
   localparam int AW   = 16;
   localparam int N    = ROWS + COLS;
   localparam int WW   = COLS * DW;
   localparam int VW   = ROWS * DW;
   localparam longint SMAX = (longint'(1) << (AW - 1)) - 1;
   localparam longint SMIN = -(longint'(1) << (AW - 1));

   typedef struct {
      int                 cyc;
      logic [COLS*AW-1:0] data;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              w_valid, w_ready;
   logic [WW-1:0]     w_data;
   logic              a_valid, a_ready;
   logic [VW-1:0]     a_data;
   logic              a_last;
   logic              y_valid;
   logic [COLS*AW-1:0] y_data;
   logic              busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_due = 0;
   int   wm [ROWS][COLS];
   int   av [ROWS];
   exp_t exp_q [$];
   logic [COLS*AW-1:0] last_y = '0;

   sys_arr_param #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
      .y_valid(y_valid), .y_data(y_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, expv);
      end
   endtask

   // Dot product per column, accumulated row by row with wrap or clamp after each add.
   function automatic logic [COLS*AW-1:0] model(input int v [ROWS]);
      logic [COLS*AW-1:0] y;
      longint s;
      logic signed [AW-1:0] t;
      y = '0;
      for (int c = 0; c < COLS; c++) begin
         s = 0;
         for (int r = 0; r < ROWS; r++) begin
            s = s + longint'(v[r]) * longint'(wm[r][c]);
`ifdef SYS_ARR_SAT_EN
            if (s > SMAX) s = SMAX;
            else if (s < SMIN) s = SMIN;
`else
            t = AW'(s);
            s = longint'(t);
`endif
         end
         y[c*AW +: AW] = AW'(s);
      end
      return y;
   endfunction

   function automatic int rnd_op();
      logic signed [DW-1:0] t;
      case ($urandom_range(0, 7))
         0: t = {1'b1, {(DW-1){1'b0}}};
         1: t = {1'b0, {(DW-1){1'b1}}};
         default: t = DW'($urandom);
      endcase
      return int'(t);
   endfunction

   // Output monitor: y_valid must match the scoreboard cycle-for-cycle; y_data holds otherwise.
   initial begin
      logic ev;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_y = '0;
         end else begin
            ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            chk("y_valid", 64'(y_valid), 64'(ev));
            if (ev) begin
               chk("y_data", 64'(y_data), 64'(exp_q[0].data));
               void'(exp_q.pop_front());
            end else begin
               chk("y_hold", 64'(y_data), 64'(last_y));
            end
            last_y = y_data;
         end
      end
   end

   task automatic load_w();
      for (int k = 0; k < ROWS; k++) begin
         w_valid = 1'b1;
         for (int c = 0; c < COLS; c++) w_data[c*DW +: DW] = DW'(wm[k][c]);
         a_valid = 1'b1;
         a_last  = 1'b1;
         a_data  = VW'($urandom);
         if (k == 0) chk("busy_idle", 64'(busy), 64'(0));
         chk("w_ready_load", 64'(w_ready), 64'(1));
         chk("a_ready_load", 64'(a_ready), 64'(0));
         @(negedge clk);
      end
      w_valid = 1'b0;
      a_valid = 1'b0;
      a_last  = 1'b0;
      chk("busy_run", 64'(busy), 64'(1));
      chk("a_ready_run", 64'(a_ready), 64'(1));
      chk("w_ready_run", 64'(w_ready), 64'(0));
   endtask

   task automatic send_vec(input bit v, input bit last, input int vec [ROWS], input bit wjunk);
      exp_t e;
      a_valid = v;
      a_last  = last;
      for (int r = 0; r < ROWS; r++) a_data[r*DW +: DW] = DW'(vec[r]);
      w_valid = wjunk;
      w_data  = WW'($urandom);
      chk("a_ready_send", 64'(a_ready), 64'(1));
      chk("w_ready_send", 64'(w_ready), 64'(0));
      if (v) begin
         e.cyc  = cyc + 1 + N;
         e.data = model(vec);
         exp_q.push_back(e);
         if (last) last_due = e.cyc;
      end
      @(negedge clk);
      a_valid = 1'b0;
      a_last  = 1'b0;
      w_valid = 1'b0;
   endtask

   task automatic stream(input int n, input bit bubbles, input bit wjunk, input bit with_last);
      int  vv [ROWS];
      bit  v, last;
      for (int i = 0; i < n; i++) begin
         for (int r = 0; r < ROWS; r++) vv[r] = rnd_op();
         v    = !bubbles || ($urandom_range(0, 2) != 0) || (i == n - 1);
         last = with_last && (i == n - 1);
         if (!v) last = ($urandom_range(0, 1) == 1);
         send_vec(v, last, vv, wjunk && !(with_last && (i == n - 1)));
      end
   endtask

   task automatic drain_check();
      repeat (last_due - cyc) @(negedge clk);
      chk("drain_busy", 64'(busy), 64'(1));
      chk("drain_last_y", 64'(y_valid), 64'(1));
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_w_ready", 64'(w_ready), 64'(1));
   endtask

   initial begin
      rst = 1'b1; w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0; a_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_w_ready", 64'(w_ready), 64'(1));
      chk("rst_a_ready", 64'(a_ready), 64'(0));
      chk("rst_y_valid", 64'(y_valid), 64'(0));
      chk("rst_y_data", 64'(y_data), 64'(0));
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);

      // Identity weights: y equals the first COLS activations after exactly N cycles.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = (r == c) ? 1 : 0;
      load_w();
      av = '{5, -3, 7, -2};
      send_vec(1'b1, 1'b1, av, 1'b0);
      repeat (N - 1) @(negedge clk);
      chk("ident_early", 64'(y_valid), 64'(0));
      @(negedge clk);
      chk("ident_valid", 64'(y_valid), 64'(1));
      chk("ident_data", 64'(y_data), 64'(48'h0007_FFFD_0005));
      drain_check();

      // Activations offered in IDLE are ignored.
      a_valid = 1'b1; a_data = VW'($urandom);
      repeat (3) begin
         chk("a_ready_idle", 64'(a_ready), 64'(0));
         @(negedge clk);
      end
      a_valid = 1'b0;

      // Random weights, bubbles, stray a_last and w_valid held during RUN.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = rnd_op();
      load_w();
      stream(14, 1'b1, 1'b1, 1'b1);
      drain_check();

      // Overflow with all-maximum operands.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = 127;
      load_w();
      av = '{127, 127, 127, 127};
      send_vec(1'b1, 1'b0, av, 1'b0);
      repeat (N) @(negedge clk);
`ifdef SYS_ARR_SAT_EN
      chk("ovf_data", 64'(y_data), 64'({COLS{16'h7FFF}}));
`else
      chk("ovf_data", 64'(y_data), 64'({COLS{16'hFC04}}));
`endif
      stream(8, 1'b0, 1'b0, 1'b1);
      drain_check();

      // Reset two cycles after an accept discards the in-flight vector.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = rnd_op();
      load_w();
      stream(1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_y_valid", 64'(y_valid), 64'(0));
      chk("midrst_y_data", 64'(y_data), 64'(0));
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (N + 2) @(negedge clk);
      chk("postrst_busy", 64'(busy), 64'(0));

      // Full reload after reset, back-to-back stream.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) wm[r][c] = rnd_op();
      load_w();
      stream(10, 1'b0, 1'b0, 1'b1);
      drain_check();

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
